// File: rtl/lift_pkg.sv
// Shared types and constants for the 7-floor lift director.
package lift_pkg;

  typedef enum logic [1:0] {
    STOP   = 2'b00,
    DOWN   = 2'b01,
    UP     = 2'b10,
    UPDOWN = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    IDLE,
    MOVE,
    DOOR
  } state_t;

  localparam int unsigned NFLOORS = 7;
  localparam logic [2:0]  F_FST   = 3'd1;
  localparam logic [2:0]  F_LST   = 3'd7;
  localparam logic        ON      = 1'b1;
  localparam logic        OFF     = 1'b0;

endpackage

// File: rtl/lift_request_reg.sv
// Car/hall request latches with per-floor clear and above/below/here reduction
// evaluated against a caller-supplied floor.
module lift_request_reg
  import lift_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [NFLOORS-1:0] car_call,
  input  logic [NFLOORS-1:0] hall_up,
  input  logic [NFLOORS-1:0] hall_down,
  input  logic [2:0]         floor,
  input  logic               clear,
  output logic [NFLOORS-1:0] req_lamp,
  output logic               above,
  output logic               below,
  output logic               here,
  output logic               here_car,
  output logic               here_up,
  output logic               here_dn,
  output logic               press_here
);

  logic [NFLOORS-1:0] car_req, up_req, dn_req;
  logic [NFLOORS-1:0] car_req_d, up_req_d, dn_req_d;
  logic [NFLOORS-1:0] clr_mask, up_set, dn_set, any_req;

  always_comb begin
    clr_mask   = '0;
    above      = OFF;
    below      = OFF;
    here       = OFF;
    here_car   = OFF;
    here_up    = OFF;
    here_dn    = OFF;
    press_here = OFF;
    // No up button on the top floor, no down button on the bottom floor.
    up_set     = hall_up & 7'b0111111;
    dn_set     = hall_down & 7'b1111110;
    any_req    = car_req | up_req | dn_req;
    for (int i = 0; i < int'(NFLOORS); i++) begin
      if (floor == 3'(i + 1)) begin
        clr_mask[i] = clear;
        here        = any_req[i];
        here_car    = car_req[i];
        here_up     = up_req[i];
        here_dn     = dn_req[i];
        press_here  = car_call[i] | up_set[i] | dn_set[i];
      end
      if (any_req[i] && (3'(i + 1) > floor)) above = ON;
      if (any_req[i] && (3'(i + 1) < floor)) below = ON;
    end
    // Clear wins over a same-cycle set.
    car_req_d = (car_req | car_call) & ~clr_mask;
    up_req_d  = (up_req | up_set) & ~clr_mask;
    dn_req_d  = (dn_req | dn_set) & ~clr_mask;
    req_lamp  = any_req;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      car_req <= '0;
      up_req  <= '0;
      dn_req  <= '0;
    end else begin
      car_req <= car_req_d;
      up_req  <= up_req_d;
      dn_req  <= dn_req_d;
    end
  end

endmodule

// File: rtl/lift_director.sv
// Lift request scheduler: floor tracking from motion-unit edges, sweep-based
// stop decisions and door timing.
module lift_director
  import lift_pkg::*;
#(
  parameter int unsigned DOOR_CYCLES = 10000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] car_call,
  input  logic [6:0] hall_up,
  input  logic [6:0] hall_down,
  input  logic [2:0] nextFloor,
  input  logic       move,
  output logic [2:0] currentFloor,
  output logic [1:0] currentDirection,
  output logic       hold,
  output logic [6:0] req_lamp
);

  localparam int unsigned TW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [TW-1:0] TLOAD = TW'(DOOR_CYCLES - 1);

  state_t          state_q, state_d;
  dir_t            sweep_q, sweep_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [2:0]      floor_q, floor_d, target_q, target_d;
  logic            move_q, rise, fall, clear;
  logic            above, below, here, here_car, here_up, here_dn, press_here;
  logic            ahead, behind, hall_match;

  assign rise = move & ~move_q;
  assign fall = ~move & move_q;

  // Requests are judged against the floor the car will be at after this edge.
  lift_request_reg u_req (
    .clk        (clk),
    .reset      (reset),
    .car_call   (car_call),
    .hall_up    (hall_up),
    .hall_down  (hall_down),
    .floor      (floor_d),
    .clear      (clear),
    .req_lamp   (req_lamp),
    .above      (above),
    .below      (below),
    .here       (here),
    .here_car   (here_car),
    .here_up    (here_up),
    .here_dn    (here_dn),
    .press_here (press_here)
  );

  always_comb begin
    floor_d    = fall ? target_q : floor_q;
    target_d   = rise ? nextFloor : target_q;
    state_d    = state_q;
    sweep_d    = sweep_q;
    timer_d    = timer_q;
    clear      = OFF;
    ahead      = (sweep_q == UP) ? above : below;
    behind     = (sweep_q == UP) ? below : above;
    hall_match = (sweep_q == UP) ? here_up : here_dn;

    unique case (state_q)
      IDLE: begin
        if (here) begin
          state_d = DOOR;
          timer_d = TLOAD;
          clear   = ON;
        end else if (above && below) begin
          state_d = MOVE;
        end else if (above) begin
          state_d = MOVE;
          sweep_d = UP;
        end else if (below) begin
          state_d = MOVE;
          sweep_d = DOWN;
        end
      end
      MOVE: begin
        if (fall && (here_car || hall_match || !ahead)) begin
          state_d = DOOR;
          timer_d = TLOAD;
          clear   = ON;
        end
      end
      DOOR: begin
        clear = ON;
        if (press_here) begin
          timer_d = TLOAD;
        end else if (timer_q == '0) begin
          if (ahead) begin
            state_d = MOVE;
          end else if (behind) begin
            state_d = MOVE;
            sweep_d = (sweep_q == UP) ? DOWN : UP;
          end else begin
            state_d = IDLE;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Only one legal travel direction exists at the end floors.
    if (floor_d == F_LST) begin
      sweep_d = DOWN;
    end else if (floor_d == F_FST) begin
      sweep_d = UP;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      sweep_q  <= UP;
      timer_q  <= '0;
      floor_q  <= F_FST;
      target_q <= F_FST;
      move_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sweep_q  <= sweep_d;
      timer_q  <= timer_d;
      floor_q  <= floor_d;
      target_q <= target_d;
      move_q   <= move;
    end
  end

  assign currentFloor     = floor_q;
  assign currentDirection = (state_q == MOVE) ? sweep_q : STOP;
  assign hold             = (state_q == DOOR) ? ON : OFF;

endmodule

// File: tb/tb_lift_director.sv
// Self-checking bench for lift_director: directed scenarios plus random car
// calls checked against a SCAN-order service model.
module tb_lift_director;

  localparam int DC = 6;
  localparam logic [1:0] D_STOP = 2'b00;
  localparam logic [1:0] D_UP   = 2'b10;
  localparam logic [1:0] D_DN   = 2'b01;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] car_call, hall_up, hall_down;
  logic [2:0] nextFloor;
  logic       move;
  logic [2:0] currentFloor;
  logic [1:0] currentDirection;
  logic       hold;
  logic [6:0] req_lamp;

  int checks = 0;
  int fails  = 0;
  int cur_m  = 1;
  int sweep_m = 1;

  lift_director #(.DOOR_CYCLES(DC)) dut (
    .clk              (clk),
    .reset            (reset),
    .car_call         (car_call),
    .hall_up          (hall_up),
    .hall_down        (hall_down),
    .nextFloor        (nextFloor),
    .move             (move),
    .currentFloor     (currentFloor),
    .currentDirection (currentDirection),
    .hold             (hold),
    .req_lamp         (req_lamp)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One motion-unit step toward floor nf.
  task automatic step(input int nf);
    nextFloor = 3'(nf);
    move = 1'b1;
    repeat (3) tick();
    move = 1'b0;
    tick();
  endtask

  task automatic count_hold(output int n);
    n = 0;
    while (hold && n < DC * 4) begin
      n++;
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    repeat (20) tick();
    checks++; if (currentFloor !== 3'd1) begin fails++; $display("FAIL reset_floor: got %0d want 1", currentFloor); end
    checks++; if (currentDirection !== D_STOP) begin fails++; $display("FAIL reset_dir: got %b want 00", currentDirection); end
    checks++; if (hold !== 1'b0) begin fails++; $display("FAIL reset_hold: got %b want 0", hold); end
    checks++; if (req_lamp !== 7'h00) begin fails++; $display("FAIL reset_lamp: got %b want 0", req_lamp); end
  endtask

  task automatic test_trip();
    int n;
    car_call = 7'b0010000;
    tick();
    car_call = '0;
    checks++; if (req_lamp !== 7'b0010000) begin fails++; $display("FAIL trip_lamp: got %b want 0010000", req_lamp); end
    tick();
    for (int f = 2; f <= 5; f++) begin
      checks++; if (currentDirection !== D_UP) begin fails++; $display("FAIL trip_dir: got %b want 10 before floor %0d", currentDirection, f); end
      step(f);
      checks++; if (currentFloor !== 3'(f)) begin fails++; $display("FAIL trip_floor: got %0d want %0d", currentFloor, f); end
      checks++; if (hold !== (f == 5)) begin fails++; $display("FAIL trip_hold: got %b at floor %0d", hold, f); end
    end
    count_hold(n);
    checks++; if (n != DC) begin fails++; $display("FAIL trip_door_len: got %0d want %0d", n, DC); end
    checks++; if (req_lamp[4] !== 1'b0) begin fails++; $display("FAIL trip_lamp_clear: got %b want 0", req_lamp[4]); end
    cur_m = 5; sweep_m = 1;
  endtask

  task automatic test_sweep();
    int n;
    hall_down = 7'b0000100;
    car_call  = 7'b1000000;
    tick();
    hall_down = '0;
    car_call  = '0;
    checks++; if (req_lamp !== 7'b1000100) begin fails++; $display("FAIL sweep_lamp: got %b want 1000100", req_lamp); end
    tick();
    checks++; if (currentDirection !== D_UP) begin fails++; $display("FAIL sweep_pref: got %b want 10", currentDirection); end
    for (int f = 6; f <= 7; f++) begin
      step(f);
      checks++; if (currentFloor !== 3'(f)) begin fails++; $display("FAIL sweep_up_floor: got %0d want %0d", currentFloor, f); end
      checks++; if (hold !== (f == 7)) begin fails++; $display("FAIL sweep_up_hold: got %b at floor %0d", hold, f); end
    end
    count_hold(n);
    checks++; if (n != DC) begin fails++; $display("FAIL sweep_door7_len: got %0d want %0d", n, DC); end
    checks++; if (currentDirection !== D_DN) begin fails++; $display("FAIL sweep_reverse: got %b want 01", currentDirection); end
    for (int f = 6; f >= 3; f--) begin
      step(f);
      checks++; if (currentFloor !== 3'(f)) begin fails++; $display("FAIL sweep_dn_floor: got %0d want %0d", currentFloor, f); end
      checks++; if (hold !== (f == 3)) begin fails++; $display("FAIL sweep_dn_hold: got %b at floor %0d", hold, f); end
    end
    cur_m = 3; sweep_m = -1;
  endtask

  // Entered with the door just opened at floor 3.
  task automatic test_reopen();
    int n;
    repeat (2) tick();
    car_call = 7'b0000100;
    tick();
    car_call = '0;
    checks++; if (req_lamp !== 7'h00) begin fails++; $display("FAIL reopen_lamp: got %b want 0", req_lamp); end
    count_hold(n);
    checks++; if (n != DC) begin fails++; $display("FAIL reopen_len: got %0d want %0d", n, DC); end
    checks++; if (currentDirection !== D_STOP) begin fails++; $display("FAIL reopen_idle: got %b want 00", currentDirection); end
  endtask

  task automatic test_top();
    int n;
    car_call = 7'b1000000;
    tick();
    car_call = '0;
    tick();
    for (int f = 4; f <= 7; f++) begin
      checks++; if (currentDirection !== D_UP) begin fails++; $display("FAIL top_dir_up: got %b before floor %0d", currentDirection, f); end
      step(f);
      checks++; if (hold !== (f == 7)) begin fails++; $display("FAIL top_hold: got %b at floor %0d", hold, f); end
    end
    count_hold(n);
    checks++; if (n != DC) begin fails++; $display("FAIL top_door_len: got %0d want %0d", n, DC); end
    for (int i = 0; i < 20; i++) begin
      checks++; if (currentDirection === D_UP || currentDirection === 2'b11) begin fails++; $display("FAIL top_no_up: got %b at floor 7", currentDirection); end
      tick();
    end
    car_call = 7'b0000001;
    tick();
    car_call = '0;
    tick();
    checks++; if (currentDirection !== D_DN) begin fails++; $display("FAIL top_dir_dn: got %b want 01", currentDirection); end
    for (int f = 6; f >= 1; f--) begin
      checks++; if (currentDirection === 2'b11) begin fails++; $display("FAIL top_dir_11: got %b", currentDirection); end
      step(f);
      checks++; if (currentFloor !== 3'(f)) begin fails++; $display("FAIL top_dn_floor: got %0d want %0d", currentFloor, f); end
    end
    count_hold(n);
    checks++; if (n != DC) begin fails++; $display("FAIL top_door1_len: got %0d want %0d", n, DC); end
    cur_m = 1; sweep_m = 1;
  endtask

  // Random car-call batches; model serves nearest request in the current
  // sweep, reversing only when nothing remains ahead.
  task automatic test_random();
    for (int r = 0; r < 10; r++) begin
      logic [6:0] mask, pend;
      int stop, d, w, n, f;
      bit ahead;
      mask = 7'($urandom_range(1, 127));
      car_call = mask;
      tick();
      car_call = '0;
      checks++; if (req_lamp !== mask) begin fails++; $display("FAIL rnd_lamp: got %b want %b", req_lamp, mask); end
      pend = mask;
      while (pend != 0) begin
        if (pend[cur_m-1]) begin
          d = 0;
          stop = cur_m;
        end else begin
          ahead = 1'b0;
          for (int g = 1; g <= 7; g++) if (pend[g-1] && (g - cur_m) * sweep_m > 0) ahead = 1'b1;
          d = ahead ? sweep_m : -sweep_m;
          stop = cur_m;
          do stop += d; while (!pend[stop-1]);
        end
        w = 0;
        while (!hold && currentDirection === D_STOP && w < 10) begin
          tick();
          w++;
        end
        checks++;
        if (w >= 10) begin
          fails++;
          $display("FAIL rnd_react: no reaction, got dir %b want stop at %0d", currentDirection, stop);
          return;
        end
        if (d == 0) begin
          checks++; if (hold !== 1'b1) begin fails++; $display("FAIL rnd_here: got hold %b want 1 at %0d", hold, stop); end
        end else begin
          f = cur_m;
          do begin
            f += d;
            checks++;
            if (currentDirection !== ((d > 0) ? D_UP : D_DN)) begin
              fails++;
              $display("FAIL rnd_dir: got %b want %b toward %0d", currentDirection, (d > 0) ? D_UP : D_DN, f);
            end
            step(f);
            checks++; if (currentFloor !== 3'(f)) begin fails++; $display("FAIL rnd_floor: got %0d want %0d", currentFloor, f); end
            checks++; if (hold !== (f == stop)) begin fails++; $display("FAIL rnd_hold: got %b at floor %0d (stop %0d)", hold, f, stop); end
          end while (f != stop);
          cur_m = stop;
          sweep_m = d;
        end
        if (cur_m == 7) sweep_m = -1;
        if (cur_m == 1) sweep_m = 1;
        pend[stop-1] = 1'b0;
        count_hold(n);
        checks++; if (n != DC) begin fails++; $display("FAIL rnd_door_len: got %0d want %0d", n, DC); end
        checks++; if (req_lamp !== pend) begin fails++; $display("FAIL rnd_pending: got %b want %b", req_lamp, pend); end
      end
      tick();
      checks++; if (currentDirection !== D_STOP || hold !== 1'b0) begin fails++; $display("FAIL rnd_idle: got dir %b hold %b want 00/0", currentDirection, hold); end
    end
  endtask

  task automatic test_reset_mid();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    car_call = 7'b0010000;
    tick();
    car_call = '0;
    tick();
    for (int f = 2; f <= 4; f++) step(f);
    checks++; if (currentFloor !== 3'd4) begin fails++; $display("FAIL mid_floor4: got %0d want 4", currentFloor); end
    nextFloor = 3'd5;
    move = 1'b1;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    checks++; if (currentFloor !== 3'd1) begin fails++; $display("FAIL mid_reset_floor: got %0d want 1", currentFloor); end
    checks++; if (currentDirection !== D_STOP) begin fails++; $display("FAIL mid_reset_dir: got %b want 00", currentDirection); end
    checks++; if (req_lamp !== 7'h00) begin fails++; $display("FAIL mid_reset_lamp: got %b want 0", req_lamp); end
    reset = 1'b0;
    move = 1'b0;
    repeat (3) tick();
    checks++; if (currentFloor !== 3'd1 || currentDirection !== D_STOP) begin fails++; $display("FAIL mid_after: got floor %0d dir %b want 1/00", currentFloor, currentDirection); end
  endtask

  initial begin
    reset     = 1'b1;
    car_call  = '0;
    hall_up   = '0;
    hall_down = '0;
    nextFloor = 3'd1;
    move      = 1'b0;
    test_reset();
    test_trip();
    test_sweep();
    test_reopen();
    test_top();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
